multicycle_controller: RTL and testbench

Multi-cycle sequencing controller for the single-issue MIPS-subset datapath. It replaces single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback, and it waits on a shared instruction/data memory port through a ready handshake. It drives the datapath muxes, the register-file and memory enables, and the 3-bit ALU operation code. It sits between the instruction register and the datapath, alone on the shared memory port.

---
 rtl/multicycle_controller_pkg.sv | 48 ++++
 rtl/multicycle_controller_insn_decode.sv | 70 +++++++
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset controller.
// Opcode/func encodings, ALU operation codes, FSM states and instruction classes.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    typedef enum logic [2:0] {
        InsnRtype,
        InsnImm,
        InsnLoad,
        InsnLoadHalf,
        InsnStore,
        InsnBranch
    } insn_cls_e;

endpackage

// File: rtl/multicycle_controller_insn_decode.sv
// Combinational instruction decoder: opcode/func to class, ALU code, datapath selects and
// a legality flag.
module multicycle_controller_insn_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output insn_cls_e  cls_o,
    output logic [2:0] aluc_o,
    output logic       alu_src_o,
    output logic       reg_dest_o,
    output logic       legal_o
);

    always_comb begin
        cls_o      = InsnRtype;
        aluc_o     = ALU_ADD;
        alu_src_o  = 1'b0;
        reg_dest_o = 1'b0;
        legal_o    = 1'b1;

        case (opcode_i)
            OP_RTYPE: begin
                reg_dest_o = 1'b1;
                case (func_i)
                    FN_ADD:  aluc_o = ALU_ADD;
                    FN_SUB:  aluc_o = ALU_SUB;
                    FN_SLL:  aluc_o = ALU_SLL;
                    FN_SRL:  aluc_o = ALU_SRL;
                    FN_AND:  aluc_o = ALU_AND;
                    FN_OR:   aluc_o = ALU_OR;
                    FN_SLT:  aluc_o = ALU_SLT;
                    default: legal_o = 1'b0;
                endcase
            end
            OP_BEQ: begin
                cls_o  = InsnBranch;
                aluc_o = ALU_SUB;
            end
            OP_ADDI: begin
                cls_o     = InsnImm;
                alu_src_o = 1'b1;
            end
            OP_ANDI: begin
                cls_o     = InsnImm;
                aluc_o    = ALU_AND;
                alu_src_o = 1'b1;
            end
            OP_ORI: begin
                cls_o     = InsnImm;
                aluc_o    = ALU_OR;
                alu_src_o = 1'b1;
            end
            OP_LW: begin
                cls_o     = InsnLoad;
                alu_src_o = 1'b1;
            end
            OP_LH: begin
                cls_o     = InsnLoadHalf;
                alu_src_o = 1'b1;
            end
            OP_SW: begin
                cls_o     = InsnStore;
                alu_src_o = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath, sharing one
// instruction/data memory port through a ready handshake.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       mem_half,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_dest,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [2:0] aluc,
    output logic       instr_done,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;

    logic [5:0] dec_op, dec_fn;
    insn_cls_e  dec_cls;
    logic [2:0] dec_aluc;
    logic       dec_alu_src;
    logic       dec_reg_dest;
    logic       dec_legal;

    logic       mem_read_c, mem_write_c, iord_c, mem_half_c, ir_write_c, pc_write_c;
    logic       branch_c, reg_dest_c, alu_src_c, mem_to_reg_c, reg_write_c;
    logic       instr_done_c, illegal_c;
    logic [2:0] aluc_c;

    // The IR is only guaranteed from DECODE onward; later states use the latched copy.
    assign dec_op = (state_q == StDecode) ? opcode : op_q;
    assign dec_fn = (state_q == StDecode) ? func   : fn_q;

    multicycle_controller_insn_decode u_insn_decode (
        .opcode_i   (dec_op),
        .func_i     (dec_fn),
        .cls_o      (dec_cls),
        .aluc_o     (dec_aluc),
        .alu_src_o  (dec_alu_src),
        .reg_dest_o (dec_reg_dest),
        .legal_o    (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            op_q    <= 6'b0;
            fn_q    <= 6'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        fn_d         = fn_q;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        iord_c       = 1'b0;
        mem_half_c   = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        reg_dest_c   = 1'b0;
        alu_src_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        aluc_c       = ALU_ADD;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                op_d    = opcode;
                fn_d    = func;
                state_d = dec_legal ? StExec : StTrap;
            end
            StExec: begin
                aluc_c    = dec_aluc;
                alu_src_c = dec_alu_src;
                case (dec_cls)
                    InsnBranch: begin
                        branch_c     = 1'b1;
                        instr_done_c = 1'b1;
                        state_d      = StFetch;
                    end
                    InsnLoad, InsnLoadHalf, InsnStore: state_d = StMem;
                    default:                           state_d = StWb;
                endcase
            end
            StMem: begin
                iord_c     = 1'b1;
                mem_half_c = (dec_cls == InsnLoadHalf);
                if (dec_cls == InsnStore) begin
                    mem_write_c = 1'b1;
                end else begin
                    mem_read_c = 1'b1;
                end
                if (mem_ready) begin
                    if (dec_cls == InsnStore) begin
                        instr_done_c = 1'b1;
                        state_d      = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                reg_dest_c   = dec_reg_dest;
                mem_to_reg_c = (dec_cls == InsnLoad) || (dec_cls == InsnLoadHalf);
                state_d      = StFetch;
            end
            StTrap: begin
                illegal_c = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset forces FETCH, which would otherwise raise mem_read while rst is still high.
    always_comb begin
        mem_read   = mem_read_c   & ~rst;
        mem_write  = mem_write_c  & ~rst;
        iord       = iord_c       & ~rst;
        mem_half   = mem_half_c   & ~rst;
        ir_write   = ir_write_c   & ~rst;
        pc_write   = pc_write_c   & ~rst;
        branch     = branch_c     & ~rst;
        reg_dest   = reg_dest_c   & ~rst;
        alu_src    = alu_src_c    & ~rst;
        mem_to_reg = mem_to_reg_c & ~rst;
        reg_write  = reg_write_c  & ~rst;
        aluc       = rst ? 3'b000 : aluc_c;
        instr_done = instr_done_c & ~rst;
        illegal    = illegal_c    & ~rst;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected output sequences built from the
// instruction timing rules, compared every cycle, plus literal checks of known sequences.
module tb_multicycle_controller;

    localparam logic [15:0] V_MRD  = 16'h8000;
    localparam logic [15:0] V_MWR  = 16'h4000;
    localparam logic [15:0] V_IORD = 16'h2000;
    localparam logic [15:0] V_HALF = 16'h1000;
    localparam logic [15:0] V_IRW  = 16'h0800;
    localparam logic [15:0] V_PCW  = 16'h0400;
    localparam logic [15:0] V_BR   = 16'h0200;
    localparam logic [15:0] V_RDST = 16'h0100;
    localparam logic [15:0] V_ASRC = 16'h0080;
    localparam logic [15:0] V_M2R  = 16'h0040;
    localparam logic [15:0] V_RW   = 16'h0020;
    localparam logic [15:0] V_DONE = 16'h0002;
    localparam logic [15:0] V_ILL  = 16'h0001;

    localparam int C_ILL = 0;
    localparam int C_R   = 1;
    localparam int C_IMM = 2;
    localparam int C_LW  = 3;
    localparam int C_LH  = 4;
    localparam int C_SW  = 5;
    localparam int C_BEQ = 6;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [15:0] exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic [5:0] func = 6'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, iord, mem_half, ir_write, pc_write, branch;
    logic       reg_dest, alu_src, mem_to_reg, reg_write, instr_done, illegal;
    logic [2:0] aluc;
    logic [15:0] dut_vec;

    step_t       q[$];
    logic [15:0] hist[$];
    logic [15:0] exp_cur = 16'h0;
    logic        chk_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    logic [5:0] legal_ops [8] = '{6'b000000, 6'b000100, 6'b001000, 6'b100011,
                                  6'b101011, 6'b100001, 6'b001100, 6'b001101};
    logic [5:0] legal_fns [7] = '{6'b100000, 6'b100010, 6'b000000, 6'b000010,
                                  6'b100100, 6'b100101, 6'b101010};

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func       (func),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .mem_half   (mem_half),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .reg_dest   (reg_dest),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .aluc       (aluc),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    assign dut_vec = {mem_read, mem_write, iord, mem_half, ir_write, pc_write, branch,
                      reg_dest, alu_src, mem_to_reg, reg_write, aluc, instr_done, illegal};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle", dut_vec, exp_cur);
            hist.push_back(dut_vec);
        end
    end

    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                foreach (legal_fns[i]) if (legal_fns[i] == fn) return C_R;
                return C_ILL;
            end
            6'b000100: return C_BEQ;
            6'b001000, 6'b001100, 6'b001101: return C_IMM;
            6'b100011: return C_LW;
            6'b100001: return C_LH;
            6'b101011: return C_SW;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100010: return 3'b001;
                6'b100100: return 3'b010;
                6'b100101: return 3'b011;
                6'b000000: return 3'b100;
                6'b000010: return 3'b101;
                6'b101010: return 3'b110;
                default:   return 3'b000;
            endcase
        end
        if (op == 6'b000100) return 3'b001;
        if (op == 6'b001100) return 3'b010;
        if (op == 6'b001101) return 3'b011;
        return 3'b000;
    endfunction

    function automatic step_t junk(input logic rdy, input logic [15:0] exp);
        step_t s;
        s.op  = 6'($urandom);
        s.fn  = 6'($urandom);
        s.rdy = rdy;
        s.exp = exp;
        return s;
    endfunction

    // Expected cycle sequence of one instruction; fw/mw are wait cycles before ready.
    task automatic gen_insn(input logic [5:0] op, input logic [5:0] fn, input int fw,
                            input int mw, input int ntrap);
        int          c;
        step_t       s;
        logic [15:0] e;
        logic [15:0] base;
        c = cls_of(op, fn);
        for (int i = 0; i < fw; i++) q.push_back(junk(1'b0, V_MRD));
        q.push_back(junk(1'b1, V_MRD | V_IRW | V_PCW));
        s.op  = op;
        s.fn  = fn;
        s.rdy = 1'($urandom);
        s.exp = 16'h0;
        q.push_back(s);
        if (c == C_ILL) begin
            for (int i = 0; i < ntrap; i++) q.push_back(junk(1'($urandom), V_ILL));
            return;
        end
        e = {11'b0, alu_of(op, fn), 2'b0};
        if (c != C_R && c != C_BEQ) e |= V_ASRC;
        if (c == C_BEQ) e |= V_BR | V_DONE;
        q.push_back(junk(1'($urandom), e));
        if (c == C_BEQ) return;
        if (c == C_LW || c == C_LH || c == C_SW) begin
            base = V_IORD | ((c == C_SW) ? V_MWR : V_MRD) | ((c == C_LH) ? V_HALF : 16'h0);
            for (int i = 0; i < mw; i++) q.push_back(junk(1'b0, base));
            q.push_back(junk(1'b1, base | ((c == C_SW) ? V_DONE : 16'h0)));
            if (c == C_SW) return;
        end
        e = V_RW | V_DONE;
        if (c == C_R) e |= V_RDST;
        if (c == C_LW || c == C_LH) e |= V_M2R;
        q.push_back(junk(1'($urandom), e));
    endtask

    // Entered and left just after a rising edge.
    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s         = q.pop_front();
            opcode    = s.op;
            func      = s.fn;
            mem_ready = s.rdy;
            exp_cur   = s.exp;
            chk_en    = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 chk("rst_async", dut_vec, 16'h0);
        @(posedge clk);
        #1 chk("rst_hold", dut_vec, 16'h0);
        rst = 1'b0;
    endtask

    task automatic lit(input string name, input int idx, input logic [15:0] exp);
        if (idx < hist.size()) begin
            chk(name, hist[idx], exp);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no cycle %0d recorded (have %0d), expected %h",
                     name, idx, hist.size(), exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         keep;

        repeat (2) @(posedge clk);
        #1 chk("rst_init", dut_vec, 16'h0);
        rst = 1'b0;

        hist.delete();
        gen_insn(6'b000000, 6'b100000, 0, 0, 0);
        gen_insn(6'b100011, 6'b000000, 0, 2, 0);
        gen_insn(6'b000100, 6'b000000, 0, 0, 0);
        gen_insn(6'b101011, 6'b000000, 0, 0, 0);
        gen_insn(6'b000000, 6'b100000, 0, 0, 0);
        run_q();
        lit("add_fetch", 0, 16'h8C00);
        lit("add_exec", 2, 16'h0000);
        lit("add_wb", 3, 16'h0122);
        lit("add_next_fetch", 4, 16'h8C00);
        lit("lw_mem_wait0", 7, 16'hA000);
        lit("lw_mem_wait1", 8, 16'hA000);
        lit("lw_mem_ready", 9, 16'hA000);
        lit("lw_wb", 10, 16'h0062);
        lit("beq_exec", 13, 16'h0206);
        lit("beq_next_fetch", 14, 16'h8C00);
        lit("sw_exec", 16, 16'h0080);
        lit("sw_mem_ready", 17, 16'h6002);

        // lh interrupted by reset while waiting in MEM
        gen_insn(6'b100001, 6'b000000, 1, 10, 0);
        keep = 1 + 1 + 1 + 1 + 2;
        while (q.size() > keep) void'(q.pop_back());
        run_q();
        mem_ready = 1'b0;
        #1 chk("lh_mem_before_rst", dut_vec, V_MRD | V_IORD | V_HALF);
        do_reset();
        gen_insn(6'b001101, 6'b000000, 1, 0, 0);
        run_q();

        gen_insn(6'b111111, 6'b000000, 0, 0, 3);
        run_q();
        do_reset();
        gen_insn(6'b000000, 6'b000111, 1, 0, 2);
        run_q();
        do_reset();
        gen_insn(6'b000000, 6'b101010, 0, 0, 0);
        run_q();

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                    if ($urandom_range(0, 1) == 1) op = 6'b000000;
                end while (cls_of(op, fn) != C_ILL);
                gen_insn(op, fn, int'($urandom_range(0, 2)), 0, int'($urandom_range(1, 3)));
                run_q();
                do_reset();
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
                fn = (op == 6'b000000) ? legal_fns[$urandom_range(0, 6)] : 6'($urandom);
                gen_insn(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
                run_q();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
